magnitude_pipe: RTL and testbench
=================================

Name: magnitude_pipe

Overview:
- Streaming, parametrised absolute-value/saturation stage for the FIR filter datapath; successor to the combinational 2's-complement magnitude block.
- Takes signed or unsigned samples over a valid/ready handshake, computes |x|, and saturates to OUT_WIDTH instead of truncating.
- Two-stage registered pipeline with full backpressure support.
- Sits between the FIR accumulator output and the downstream result register/output interface.

Parameters:
- IN_WIDTH, 17, input sample width (two's complement in signed mode).
- OUT_WIDTH, 16, output magnitude width; legal range 1..IN_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- signed_mode  input  1  1: in_data is two's complement; 0: in_data is unsigned. Sampled with each accepted sample.
- in_data  input  IN_WIDTH  input sample.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a sample this cycle.
- out_data  output  OUT_WIDTH  saturated magnitude.
- out_sat  output  1  out_data was clipped; qualified by out_valid.
- out_valid  output  1  out_data/out_sat valid.
- out_ready  input  1  downstream accepts.
- peak_clr  input  1  clear peak register (feature only).
- peak_mag  output  OUT_WIDTH  running maximum of emitted out_data (feature only).

Behaviour:
- Reset values: out_data=0, out_sat=0, out_valid=0, internal stage-1 valid=0, peak_mag=0. in_ready is combinational and reads 1 while stage 1 is empty.
- Transfers: an input transfer occurs when in_valid&&in_ready; an output transfer occurs when out_valid&&out_ready. out_data/out_sat are held stable while out_valid&&!out_ready.
- Stage 1 (S1):
  - Registers the sample and the mode.
  - Computes magnitude into an IN_WIDTH-bit register: signed_mode&&msb=1 -> (~in_data)+1, else in_data.
  - Most-negative input (e.g. 17'h10000) yields 2^(IN_WIDTH-1) with no wrap.
- Stage 2 (S2):
  - Saturation: if magnitude > 2^OUT_WIDTH-1, out_data = all ones and out_sat = 1.
  - Otherwise out_data = magnitude[OUT_WIDTH-1:0] and out_sat = 0.
- Advance rules:
  - S2 loads when S1 is valid and (!out_valid || out_ready).
  - S1 loads on an input transfer.
  - in_ready = !s1_valid || S2 loads this cycle.
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput is 1 sample/cycle.
- Full condition: both stages valid and out_ready=0 -> in_ready=0 and no state changes.
- Simultaneous events: output transfer and input transfer in the same cycle are both honoured with no bubble.
- Ordering: output order equals input order; no sample is dropped or duplicated.
- Reset mid-operation: in-flight samples are discarded and all valids clear immediately (asynchronous). No output transfer may be reported for discarded data.
- signed_mode change mid-stream affects only samples accepted after the change.

Optional Feature:
- Macro: MAGNITUDE_PEAK_EN.
- Defined:
  - peak_mag updates on each output transfer to max(peak_mag, out_data).
  - peak_clr=1 loads peak_mag with 0 that cycle; if an output transfer coincides, it loads that transfer's out_data instead.
  - Reset value 0.
- Undefined:
  - peak_clr is ignored.
  - peak_mag is tied to 0 and no peak register is synthesised.

Decomposition:
- Shared package magnitude_pkg:
  - default IN_WIDTH/OUT_WIDTH localparams;
  - typedef enum logic {MODE_UNSIGNED=0, MODE_SIGNED=1} mag_mode_t.
- One natural sub-module: abs_sat, a purely combinational saturate-and-flag function parametrised on IN_WIDTH/OUT_WIDTH, used by S2.

Test Plan:
- Signed sign/boundary cases, out_ready=1: in 17'h1FFFF (-1) -> out_data 16'h0001, out_sat 0, out_valid 2 cycles after accept; in 17'h0FFFF -> 16'hFFFF, sat 0.
- Signed most-negative: in 17'h10000 -> 16'hFFFF, out_sat 1.
- Signed in 17'h10001 (-65535) -> 16'hFFFF, sat 0.
- Unsigned mode: in 17'h10000 -> 16'hFFFF, sat 1; in 17'h00123 -> 16'h0123, sat 0; same inputs in signed mode -> 16'hFFFF sat 1 and 16'h0123 sat 0.
- Backpressure: stream 1..6 back-to-back with out_ready low for cycles 3-7 -> in_ready falls once two samples are held, out_data stays stable, all six emerge in order, no bubble after out_ready returns.
- Reset mid-operation: rst pulsed with both stages full -> out_valid=0 and in_ready=1 immediately; post-reset sample 17'h00005 -> 16'h0005 after 2 cycles, earlier data never emitted.
- MAGNITUDE_PEAK_EN: emit 3, 9, 4 -> peak_mag 3, 9, 9; peak_clr with concurrent emit of 2 -> peak_mag 2; without macro peak_mag stays 0.

Source files
------------

// File: rtl/magnitude_pkg.sv
// Shared definitions for the magnitude pipeline: default widths and the sample-mode encoding.
package magnitude_pkg;
    localparam int MAG_IN_WIDTH  = 17;
    localparam int MAG_OUT_WIDTH = 16;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mag_mode_t;
endpackage

// File: rtl/magnitude_pipe_if.sv
// Sample-in / magnitude-out stream bundle for magnitude_pipe.
// The upstream/downstream side uses the master modport, and the pipeline uses the slave modport.
interface magnitude_pipe_if
    import magnitude_pkg::*;
#(
    parameter int IN_WIDTH  = MAG_IN_WIDTH,
    parameter int OUT_WIDTH = MAG_OUT_WIDTH
);
    logic                 signed_mode;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_sat;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output signed_mode, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sat, out_valid
    );

    modport slave (
        input  signed_mode, in_data, in_valid, out_ready,
        output in_ready, out_data, out_sat, out_valid
    );
endinterface

// File: rtl/magnitude_pipe_abs_sat.sv
// Combinational clip of an IN_WIDTH-bit magnitude to OUT_WIDTH bits, with a clip flag.
module abs_sat
    import magnitude_pkg::*;
#(
    parameter int IN_WIDTH  = MAG_IN_WIDTH,
    parameter int OUT_WIDTH = MAG_OUT_WIDTH
) (
    input  logic [IN_WIDTH-1:0]  mag_i,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 sat_o
);
    logic over;

    // When the widths are equal, there are no upper bits that could overflow.
    generate
        if (OUT_WIDTH < IN_WIDTH) begin : g_clip
            assign over = |mag_i[IN_WIDTH-1:OUT_WIDTH];
        end else begin : g_fit
            assign over = 1'b0;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_bit
            assign data_o[gi] = mag_i[gi] | over;
        end
    endgenerate

    assign sat_o = over;
endmodule

// File: rtl/magnitude_pipe.sv
// Two-stage streaming |x| with saturation to OUT_WIDTH and full backpressure.
// Defining MAGNITUDE_PEAK_EN adds a running peak register on the emitted magnitudes.
module magnitude_pipe
    import magnitude_pkg::*;
#(
    parameter int IN_WIDTH  = MAG_IN_WIDTH,
    parameter int OUT_WIDTH = MAG_OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    magnitude_pipe_if.slave      bus,
    input  logic                 peak_clr,
    output logic [OUT_WIDTH-1:0] peak_mag
);
    mag_mode_t            in_mode;
    logic [IN_WIDTH-1:0]  in_mag;
    logic                 in_ready_w;
    logic                 in_fire;
    logic                 out_fire;
    logic                 s2_load;
    logic [OUT_WIDTH-1:0] sat_data;
    logic                 sat_flag;

    logic                 s1_valid_q, s1_valid_d;
    logic [IN_WIDTH-1:0]  s1_mag_q, s1_mag_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_sat_q, out_sat_d;

    assign in_mode = mag_mode_t'(bus.signed_mode);
    // The S1 register is IN_WIDTH bits wide, so negating the most-negative value yields 2^(IN_WIDTH-1) with no wrap.
    assign in_mag  = (in_mode == MODE_SIGNED && bus.in_data[IN_WIDTH-1])
                     ? (~bus.in_data + IN_WIDTH'(1)) : bus.in_data;

    assign s2_load    = s1_valid_q && (!out_valid_q || bus.out_ready);
    assign in_ready_w = !s1_valid_q || s2_load;
    assign in_fire    = bus.in_valid && in_ready_w;
    assign out_fire   = out_valid_q && bus.out_ready;

    abs_sat #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_abs_sat (
        .mag_i (s1_mag_q),
        .data_o(sat_data),
        .sat_o (sat_flag)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_mag_d    = s1_mag_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (out_fire) begin
            out_valid_d = 1'b0;
        end
        if (s2_load) begin
            out_valid_d = 1'b1;
            out_data_d  = sat_data;
            out_sat_d   = sat_flag;
            s1_valid_d  = 1'b0;
        end
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_mag_d   = in_mag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_mag_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mag_q    <= s1_mag_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

`ifdef MAGNITUDE_PEAK_EN
    logic [OUT_WIDTH-1:0] peak_q, peak_d;

    // A clear coinciding with an emit restarts the peak from that emitted value.
    always_comb begin
        peak_d = peak_q;
        if (peak_clr) begin
            peak_d = out_fire ? out_data_q : '0;
        end else if (out_fire && (out_data_q > peak_q)) begin
            peak_d = out_data_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_mag = peak_q;
`else
    logic peak_clr_unused;
    assign peak_clr_unused = peak_clr;
    assign peak_mag        = '0;
`endif
endmodule

// File: tb/tb_magnitude_pipe.sv
// Directed-vector bench for magnitude_pipe with a queue-based reference model checked every cycle.
module tb_magnitude_pipe;
    import magnitude_pkg::*;

    localparam int IW = 17;
    localparam int OW = 16;
`ifdef MAGNITUDE_PEAK_EN
    localparam bit PEAK = 1'b1;
`else
    localparam bit PEAK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          peak_clr = 1'b0;
    logic [OW-1:0] peak_mag;

    always #5 clk = ~clk;

    magnitude_pipe_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    magnitude_pipe #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .peak_clr(peak_clr),
        .peak_mag(peak_mag)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: magnitude by integer arithmetic, then clip to the largest OW-bit value.
    function automatic logic [OW:0] model(input bit sgn, input logic [IW-1:0] x);
        longint     v;
        longint     maxv;
        logic [63:0] u;
        v    = sgn ? longint'($signed(x)) : longint'({1'b0, x});
        maxv = (longint'(1) << OW) - 1;
        if (v < 0) v = -v;
        if (v > maxv) return {1'b1, {OW{1'b1}}};
        u = v;
        return {1'b0, u[OW-1:0]};
    endfunction

    logic [OW:0]   exp_q[$];
    logic [OW:0]   exp_e;
    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_data;
    logic          prev_sat;
    logic [OW-1:0] peak_model = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
            peak_model = '0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", bus.out_valid, 1'b1);
                check("hold_data", bus.out_data, prev_data);
                check("hold_sat", bus.out_sat, prev_sat);
            end
            check("peak_mag", peak_mag, peak_model);
            if (bus.out_valid && bus.out_ready) begin
                check("out_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    check("out_data", bus.out_data, exp_e[OW-1:0]);
                    check("out_sat", bus.out_sat, exp_e[OW]);
                    $display("emit data=%04h sat=%0d", bus.out_data, bus.out_sat);
                end
            end
            if (PEAK) begin
                if (peak_clr)
                    peak_model = (bus.out_valid && bus.out_ready) ? bus.out_data : '0;
                else if (bus.out_valid && bus.out_ready && bus.out_data > peak_model)
                    peak_model = bus.out_data;
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.signed_mode, bus.in_data));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_sat   = bus.out_sat;
        end
    end

    // Single sample with out_ready=1: out_valid must rise exactly two edges after presentation.
    task automatic send_one(input bit mode, input logic [IW-1:0] d,
                            input logic [OW-1:0] exp_d, input bit exp_s);
        @(posedge clk); #1;
        bus.signed_mode = mode;
        bus.in_data     = d;
        bus.in_valid    = 1'b1;
        check("accept_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("lat_s1_only", bus.out_valid, 1'b0);
        @(posedge clk); #1;
        check("lat_valid", bus.out_valid, 1'b1);
        check("lit_data", bus.out_data, exp_d);
        check("lit_sat", bus.out_sat, exp_s);
        $display("xfer mode=%0d in=%05h -> out=%04h sat=%0d", mode, d, bus.out_data, bus.out_sat);
    endtask

    typedef struct {
        bit            mode;
        logic [IW-1:0] d;
        logic [OW-1:0] e;
        bit            s;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 17'h1FFFF, 16'h0001, 1'b0};
        vecs[1] = '{1'b1, 17'h0FFFF, 16'hFFFF, 1'b0};
        vecs[2] = '{1'b1, 17'h10000, 16'hFFFF, 1'b1};
        vecs[3] = '{1'b1, 17'h10001, 16'hFFFF, 1'b0};
        vecs[4] = '{1'b0, 17'h10000, 16'hFFFF, 1'b1};
        vecs[5] = '{1'b0, 17'h00123, 16'h0123, 1'b0};
        vecs[6] = '{1'b1, 17'h10000, 16'hFFFF, 1'b1};
        vecs[7] = '{1'b1, 17'h00123, 16'h0123, 1'b0};

        bus.signed_mode = 1'b0;
        bus.in_data     = '0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b1;

        #12;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 16'h0000);
        check("rst_out_sat", bus.out_sat, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_peak", peak_mag, 16'h0000);
        @(posedge clk); #2;
        rst = 1'b0;

        foreach (vecs[i]) send_one(vecs[i].mode, vecs[i].d, vecs[i].e, vecs[i].s);

        // Backpressure: samples 1..6 back to back, out_ready low in cycles 3..7.
        @(posedge clk); #1;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    int w;
                    bus.signed_mode = 1'b0;
                    bus.in_data     = IW'(i);
                    bus.in_valid    = 1'b1;
                    w = 0;
                    @(negedge clk);
                    while (!bus.in_ready && w < 50) begin
                        @(negedge clk);
                        w++;
                    end
                    check("bp_accept_timeout", w < 50, 1'b1);
                    @(posedge clk); #1;
                end
                bus.in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 14; c++) begin
                    bus.out_ready = !(c >= 3 && c <= 7);
                    @(negedge clk);
                    if (c == 5) begin
                        check("bp_in_ready_low", bus.in_ready, 1'b0);
                        check("bp_full_valid", bus.out_valid, 1'b1);
                    end
                    if (c >= 8 && c <= 12) check("bp_no_bubble", bus.out_valid, 1'b1);
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("bp_all_emitted", exp_q.size(), 0);

        // Reset with both stages full.
        @(posedge clk); #1;
        bus.out_ready   = 1'b0;
        bus.signed_mode = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_data     = 17'h00AAA;
        @(posedge clk); #1;
        bus.in_data = 17'h1F000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("full_in_ready", bus.in_ready, 1'b0);
        check("full_out_valid", bus.out_valid, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("arst_out_valid", bus.out_valid, 1'b0);
        check("arst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk); #2;
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        send_one(1'b1, 17'h00005, 16'h0005, 1'b0);

        // Peak tracking; without the feature, peak_mag must stay 0.
        send_one(1'b0, 17'h00003, 16'h0003, 1'b0);
        @(posedge clk); #1;
        check("peak_after_3", peak_mag, PEAK ? 16'd3 : 16'd0);
        send_one(1'b0, 17'h00009, 16'h0009, 1'b0);
        @(posedge clk); #1;
        check("peak_after_9", peak_mag, PEAK ? 16'd9 : 16'd0);
        send_one(1'b0, 17'h00004, 16'h0004, 1'b0);
        @(posedge clk); #1;
        check("peak_after_4", peak_mag, PEAK ? 16'd9 : 16'd0);
        send_one(1'b0, 17'h00002, 16'h0002, 1'b0);
        peak_clr = 1'b1;
        @(posedge clk); #1;
        peak_clr = 1'b0;
        check("peak_clr_emit", peak_mag, PEAK ? 16'd2 : 16'd0);

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
